ex_muldiv: RTL and testbench
============================

Name: ex_muldiv

Overview:
- Iterative RV32M multiply/divide unit beside the single-cycle execute stage.
- Accepts one operation on a start pulse and holds the pipeline through stall_o while it iterates.
- Returns the result with its destination register for the write-back path.
- Generalised in operand width (XLEN) and register-address width. Adds multi-cycle state, a flush/abort path and RISC-V divide corner-case handling, none of which the combinational ALU path has.

Parameters:
- XLEN, 32: operand/result width; must be even and >= 8.
- REG_ADDR_W, 5: destination register address width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request; sampled only in IDLE
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1_i  input  XLEN  rs1 operand (multiplicand / dividend)
- src2_i  input  XLEN  rs2 operand (multiplier / divisor)
- w_reg_addr_i  input  REG_ADDR_W  destination register
- flush_i  input  1  abort the current operation (branch mispredict / exception)
- busy_o  output  1  state != IDLE
- stall_o  output  1  pipeline hold request
- result_valid_o  output  1  one-cycle result strobe
- result_o  output  XLEN  result, valid with result_valid_o
- w_reg_addr_o  output  REG_ADDR_W  captured destination
- w_reg_enable_o  output  1  equals result_valid_o

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. On reset, in any state, every output and register goes to 0 and the FSM goes to IDLE.
- States: IDLE, CALC, DONE.
- IDLE -> CALC: start_i=1 and flush_i=0. On this edge the unit captures op, |src1|, |src2| (signed ops use the two's-complement magnitude), the result sign flags, w_reg_addr_i, and sets counter=0.
- CALC: one iteration per cycle; counter increments. When counter reaches XLEN-1, the next state is DONE.
- Multiply: radix-2 shift-add into a 2*XLEN accumulator.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits after sign correction of the full 2*XLEN product.
  - MULHSU treats src1 as signed and src2 as unsigned.
- Divide: restoring division, one quotient bit per cycle.
  - Quotient sign = sign(src1) XOR sign(src2).
  - Remainder sign = sign(src1).
- Divide-by-zero: quotient = all ones, remainder = src1 (RISC-V rule); signs are not applied.
- Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1), remainder = 0.
- DONE: result_valid_o=1 and w_reg_enable_o=1 for exactly one cycle, with result_o and w_reg_addr_o stable. The next state is always IDLE.
- Latency: result_valid_o is high in the cycle after XLEN+1 rising edges following the accepting edge (33 for XLEN=32).
- Back-to-back: start_i is ignored in DONE. A new op can be accepted in the IDLE cycle that follows DONE.
- stall_o = (state==CALC) | (state==IDLE & start_i & ~flush_i). It is low in DONE so the pipeline advances with the result.
- result_o holds its last value outside DONE. Consumers must qualify it with result_valid_o.
- flush_i=1 in any state: next state is IDLE and no result_valid_o is produced for the aborted op. flush_i wins over a simultaneous start_i. A flush during DONE does not suppress the already-asserted strobe of that cycle.
- busy_o is 1 in CALC and DONE.

Optional Feature:
- Macro: EX_MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, when start is accepted and the op is a divide with src2==0, or any op with src1==0 or src2==0, the FSM goes directly to DONE. result_valid_o appears after 1 edge, and stall_o covers only the accept cycle.
- Not defined: all ops take the full XLEN+1 latency. Results are bit-identical in both builds.

Test Plan:
- Reset: rst_n low mid-CALC -> all outputs 0 immediately, IDLE. Then MUL 7*6 -> result_o=42 after 33 edges, w_reg_enable_o one cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MULHU of the same operands -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Latency 33 edges without the macro, 1 edge with it.
- flush_i pulsed at CALC cycle 10 -> IDLE next edge, no result_valid_o. start_i+flush_i together in IDLE -> not accepted, stall_o=0.
- Back-to-back: start_i held high -> the second op is accepted in the IDLE cycle after DONE, w_reg_addr_o tracks each op, no start is accepted during CALC/DONE.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the execute stage.
//
// One operation is accepted on start_i while IDLE. The unit then iterates one
// bit per cycle (radix-2 shift-add multiply, restoring divide) on operand
// magnitudes, applies the result sign at the end and presents the result for
// exactly one cycle in DONE together with the captured destination register.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           request, sampled only in IDLE
//   op_i[2:0]         funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   src1_i, src2_i    rs1 / rs2 operands
//   w_reg_addr_i      destination register
//   flush_i           abort the current operation, wins over start_i
//   busy_o            state != IDLE
//   stall_o           pipeline hold request
//   result_valid_o    one-cycle result strobe (DONE)
//   result_o          result, qualified by result_valid_o
//   w_reg_addr_o      captured destination register
//   w_reg_enable_o    equals result_valid_o
//   state_dbg_o       FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: an operation is taken on a rising edge where the unit is IDLE,
// start_i=1 and flush_i=0; the result is delivered on result_valid_o for one
// cycle with no back-pressure, and the unit returns to IDLE afterwards.
//
// Optional build macro EX_MULDIV_EARLY_OUT_EN: an accepted op with a zero
// operand (or any divide by zero) jumps straight to DONE. Results are the
// same in both builds.
module ex_muldiv #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       src1_i,
  input  logic [XLEN-1:0]       src2_i,
  input  logic [REG_ADDR_W-1:0] w_reg_addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic                  result_valid_o,
  output logic [XLEN-1:0]       result_o,
  output logic [REG_ADDR_W-1:0] w_reg_addr_o,
  output logic                  w_reg_enable_o,
  output logic [1:0]            state_dbg_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opnd;     // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0]   acc;      // {hi, lo}: product or {remainder, quotient}
  logic                neg_q;    // negate the selected result at the end
  logic                dz_q;     // divide by zero: quotient forced to all ones

  // operand decode at accept time
  logic                accept, early_hit;
  logic                sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0]     mag1, mag2, early_res;

  // one iteration step and final result
  logic [XLEN:0]       mul_sum, div_shift;
  logic [XLEN-1:0]     div_diff, q_mag, r_mag, fin_res;
  logic [2*XLEN-1:0]   acc_next, prod;

  assign accept = (state == IDLE) && start_i && !flush_i;

  always_comb begin
    // signedness of each operand per funct3
    sgn1 = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    sgn2 = op_i[2] ? ~op_i[0] : ~op_i[1];
    neg1 = sgn1 & src1_i[XLEN-1];
    neg2 = sgn2 & src2_i[XLEN-1];
    mag1 = neg1 ? -src1_i : src1_i;
    mag2 = neg2 ? -src2_i : src2_i;
`ifdef EX_MULDIV_EARLY_OUT_EN
    early_hit = (src1_i == '0) || (src2_i == '0);
    // divide by zero: quotient all ones, remainder = dividend; otherwise 0
    early_res = (op_i[2] && (src2_i == '0)) ? (op_i[1] ? src1_i : '1) : '0;
`else
    early_hit = 1'b0;
    early_res = '0;
`endif
  end

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    // difference is below the divisor when it applies, so XLEN bits suffice
    div_diff  = div_shift[XLEN-1:0] - opnd;
    if (op_q[2]) begin
      if (div_shift >= {1'b0, opnd})
        acc_next = {div_diff, acc[XLEN-2:0], 1'b1};
      else
        acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end
    prod  = neg_q ? -acc_next : acc_next;
    q_mag = acc_next[XLEN-1:0];
    r_mag = acc_next[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:         fin_res = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fin_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: fin_res = dz_q ? '1 : (neg_q ? -q_mag : q_mag);
      default:        fin_res = neg_q ? -r_mag : r_mag;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state and outputs
  always_comb begin
    state_next     = state;
    busy_o         = 1'b0;
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = start_i & ~flush_i;
        if (accept) state_next = early_hit ? DONE : CALC;
      end
      CALC: begin
        busy_o  = 1'b1;
        stall_o = 1'b1;
        if (flush_i)          state_next = IDLE;
        else if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        busy_o         = 1'b1;
        result_valid_o = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
    w_reg_enable_o = result_valid_o;
    state_dbg_o    = state;
  end

  // datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      op_q         <= '0;
      opnd         <= '0;
      acc          <= '0;
      neg_q        <= 1'b0;
      dz_q         <= 1'b0;
      result_o     <= '0;
      w_reg_addr_o <= '0;
    end else begin
      if (accept) begin
        cnt          <= '0;
        op_q         <= op_i;
        opnd         <= op_i[2] ? mag2 : mag1;
        acc          <= {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
        // remainder follows the dividend; everything else uses the xor
        neg_q        <= (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
        dz_q         <= op_i[2] && (src2_i == '0);
        w_reg_addr_o <= w_reg_addr_i;
        if (early_hit) result_o <= early_res;
      end else if (state == CALC && !flush_i) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) result_o <= fin_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: reset, multiply/divide vectors, divide
// corner cases, latency, flush and back-to-back operation.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic [4:0]  w_reg_addr_i;
  logic        flush_i;
  logic        busy_o, stall_o, result_valid_o, w_reg_enable_o;
  logic [31:0] result_o;
  logic [4:0]  w_reg_addr_o;
  logic [1:0]  state_dbg_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef EX_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3,
                         DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

  ex_muldiv dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .w_reg_addr_i(w_reg_addr_i),
    .flush_i(flush_i), .busy_o(busy_o), .stall_o(stall_o),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .w_reg_addr_o(w_reg_addr_o), .w_reg_enable_o(w_reg_enable_o),
    .state_dbg_o(state_dbg_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; edges counts from it.
  task automatic wait_valid(output int edges, output bit got);
    edges = 1;
    got   = 1'b0;
    while (!got && edges < 100) begin
      if (result_valid_o) got = 1'b1;
      else begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] addr, input logic [31:0] exp);
    int edges;
    bit got;
    int lat;
    lat = (EARLY && (a == 32'd0 || b == 32'd0)) ? 1 : 33;
    @(negedge clk);
    op_i = op; src1_i = a; src2_i = b; w_reg_addr_i = addr; start_i = 1'b1;
    #1 check({tag, " stall_accept"}, 32'(stall_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    wait_valid(edges, got);
    check({tag, " valid_seen"}, 32'(got), 32'd1);
    check({tag, " result"}, result_o, exp);
    check({tag, " addr"}, 32'(w_reg_addr_o), 32'(addr));
    check({tag, " wen"}, 32'(w_reg_enable_o), 32'd1);
    check({tag, " stall_done"}, 32'(stall_o), 32'd0);
    check({tag, " latency"}, 32'(edges), 32'(lat));
    @(negedge clk);
    check({tag, " valid_one_cycle"}, 32'(result_valid_o), 32'd0);
  endtask

  // Watches result_valid_o for n cycles; returns how often it was high.
  task automatic count_valid(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (result_valid_o) seen++;
    end
  endtask

  initial begin
    int edges, seen;
    bit got;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op_i = 3'd0;
    src1_i = '0; src2_i = '0; w_reg_addr_i = '0;
    #12;
    check("rst result", result_o, 32'd0);
    check("rst valid", 32'(result_valid_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst addr", 32'(w_reg_addr_o), 32'd0);
    check("rst state", 32'(state_dbg_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_pre", MUL, 32'd7, 32'd6, 5'd5, 32'd42);

    // reset in the middle of CALC
    @(negedge clk);
    op_i = MUL; src1_i = 32'd3; src2_i = 32'd3; w_reg_addr_i = 5'd7; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy_o), 32'd0);
    check("midrst stall", 32'(stall_o), 32'd0);
    check("midrst result", result_o, 32'd0);
    check("midrst addr", 32'(w_reg_addr_o), 32'd0);
    check("midrst state", 32'(state_dbg_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul_7x6", MUL, 32'd7, 32'd6, 5'd5, 32'd42);
    run_op("mul_neg", MUL, 32'hFFFF_FFFD, 32'd5, 5'd1, 32'hFFFF_FFF1);
    run_op("mul_zero", MUL, 32'd0, 32'd9, 5'd2, 32'd0);
    run_op("mulh", MULH, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000);
    run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
    run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD);
    run_op("rem_m7_2", REM, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF);
    run_op("div_7_m2", DIV, 32'd7, 32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD);
    run_op("rem_7_m2", REM, 32'd7, 32'hFFFF_FFFE, 5'd11, 32'd1);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0);
    run_op("divu_100_7", DIVU, 32'd100, 32'd7, 5'd14, 32'd14);
    run_op("remu_100_7", REMU, 32'd100, 32'd7, 5'd15, 32'd2);
    run_op("divu_by0", DIVU, 32'd5, 32'd0, 5'd16, 32'hFFFF_FFFF);
    run_op("remu_by0", REMU, 32'd5, 32'd0, 5'd17, 32'd5);
    run_op("div_by0", DIV, 32'hFFFF_FFFB, 32'd0, 5'd18, 32'hFFFF_FFFF);
    run_op("rem_by0", REM, 32'hFFFF_FFFB, 32'd0, 5'd19, 32'hFFFF_FFFB);

    // flush in CALC cycle 10
    @(negedge clk);
    op_i = DIVU; src1_i = 32'd100; src2_i = 32'd7; w_reg_addr_i = 5'd20; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush state", 32'(state_dbg_o), 32'd0);
    check("flush busy", 32'(busy_o), 32'd0);
    count_valid(40, seen);
    check("flush no_valid", 32'(seen), 32'd0);

    // start and flush together in IDLE
    @(negedge clk);
    op_i = MUL; src1_i = 32'd2; src2_i = 32'd2; w_reg_addr_i = 5'd21;
    start_i = 1'b1; flush_i = 1'b1;
    #1 check("startflush stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    check("startflush busy", 32'(busy_o), 32'd0);
    count_valid(40, seen);
    check("startflush no_valid", 32'(seen), 32'd0);

    run_op("after_flush", MUL, 32'd11, 32'd11, 5'd22, 32'd121);

    // back-to-back with start_i held high
    @(negedge clk);
    op_i = MUL; src1_i = 32'd3; src2_i = 32'd4; w_reg_addr_i = 5'd3; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_i = DIVU; src1_i = 32'd50; src2_i = 32'd5; w_reg_addr_i = 5'd9;
    wait_valid(edges, got);
    check("b2b1 valid_seen", 32'(got), 32'd1);
    check("b2b1 latency", 32'(edges), 32'd33);
    check("b2b1 result", result_o, 32'd12);
    check("b2b1 addr", 32'(w_reg_addr_o), 32'd3);
    check("b2b1 stall_done", 32'(stall_o), 32'd0);
    @(negedge clk);
    check("b2b idle busy", 32'(busy_o), 32'd0);
    check("b2b idle stall", 32'(stall_o), 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    wait_valid(edges, got);
    check("b2b2 valid_seen", 32'(got), 32'd1);
    check("b2b2 latency", 32'(edges), 32'd33);
    check("b2b2 result", result_o, 32'd10);
    check("b2b2 addr", 32'(w_reg_addr_o), 32'd9);
    @(negedge clk);
    check("b2b2 valid_one_cycle", 32'(result_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
